grid_region_loader: RTL

Feeds the stroke-selection stage of the painterly renderer. It scans the 24-bit difference image in SRAM as a raster of GRID×GRID tiles and fetches each tile's pixels over a read-only memory port. It presents each completed tile as one flattened region word with a valid/ready handshake, so the downstream max-finder can locate the largest-error pixel. The block is the producer side of the region interface that the paint-layer logic consumes.

---
 rtl/paint_pkg.sv | 32 +++
 rtl/grid_region_loader_if.sv | 35 +++
 rtl/grid_addr_gen.sv | 85 ++++++++
 rtl/grid_region_loader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared painterly-renderer types: default image/tile geometry, pixel type,
// loader state encoding and the tile-relative address helper.
package paint_pkg;

  localparam int DEF_GRID  = 8;
  localparam int DEF_DW    = 24;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_AW    = 17;

  typedef logic [DEF_DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Word address of in-tile pixel (r,c) of tile (tx,ty) in a raster image.
  function automatic int unsigned tile_addr(
    input int unsigned tx,
    input int unsigned ty,
    input int unsigned r,
    input int unsigned c,
    input int unsigned img_w = DEF_IMG_W,
    input int unsigned grid  = DEF_GRID
  );
    return (ty * grid + r) * img_w + tx * grid + c;
  endfunction

endpackage

// File: rtl/grid_region_loader_if.sv
// Loader bus: in-order read port towards SRAM plus the valid/ready region port
// towards the max-finder. master = loader side, slave = memory/consumer side.
interface grid_region_loader_if
  import paint_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int GRID = DEF_GRID,
  parameter int TXW  = 6,
  parameter int TYW  = 5
);

  logic                   mem_rd;
  logic [AW-1:0]          mem_addr;
  logic                   mem_wait;
  logic [DW-1:0]          mem_rdata;
  logic                   mem_rvalid;

  logic [GRID*GRID*DW-1:0] region;
  logic                    region_valid;
  logic                    region_ready;
  logic [TXW-1:0]          tile_x;
  logic [TYW-1:0]          tile_y;

  modport master (
    output mem_rd, mem_addr, region, region_valid, tile_x, tile_y,
    input  mem_wait, mem_rdata, mem_rvalid, region_ready
  );

  modport slave (
    input  mem_rd, mem_addr, region, region_valid, tile_x, tile_y,
    output mem_wait, mem_rdata, mem_rvalid, region_ready
  );

endinterface

// File: rtl/grid_addr_gen.sv
// Tile and in-tile row/col counters producing the raster read address; address is
// combinational from the counters, which only move on an accepted request or tile handoff.
module grid_addr_gen
  import paint_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int GRID  = DEF_GRID,
  parameter int AW    = DEF_AW,
  parameter int TXW   = 6,
  parameter int TYW   = 5
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clear,
  input  logic           i_req_acc,
  input  logic           i_tile_adv,
  output logic [AW-1:0]  o_addr,
  output logic           o_last_req,
  output logic           o_last_tile,
  output logic [TXW-1:0] o_tile_x,
  output logic [TYW-1:0] o_tile_y
);

  localparam int NTX = IMG_W / GRID;
  localparam int NTY = IMG_H / GRID;
  localparam int CW  = (GRID > 1) ? $clog2(GRID) : 1;

  logic [TXW-1:0] tile_x_q, tile_x_d;
  logic [TYW-1:0] tile_y_q, tile_y_d;
  logic [CW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;

  assign o_last_req  = (row_q == CW'(GRID - 1)) && (col_q == CW'(GRID - 1));
  assign o_last_tile = (tile_x_q == TXW'(NTX - 1)) && (tile_y_q == TYW'(NTY - 1));
  assign o_addr      = AW'(tile_addr(32'(tile_x_q), 32'(tile_y_q), 32'(row_q), 32'(col_q),
                                     IMG_W, GRID));
  assign o_tile_x    = tile_x_q;
  assign o_tile_y    = tile_y_q;

  always_comb begin
    tile_x_d = tile_x_q;
    tile_y_d = tile_y_q;
    row_d    = row_q;
    col_d    = col_q;
    if (i_clear) begin
      tile_x_d = '0;
      tile_y_d = '0;
      row_d    = '0;
      col_d    = '0;
    end else if (i_tile_adv) begin
      row_d = '0;
      col_d = '0;
      // The final tile wraps both counters so the next scan starts clean.
      if (tile_x_q == TXW'(NTX - 1)) begin
        tile_x_d = '0;
        tile_y_d = o_last_tile ? '0 : tile_y_q + 1'b1;
      end else begin
        tile_x_d = tile_x_q + 1'b1;
      end
    end else if (i_req_acc) begin
      if (col_q == CW'(GRID - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(GRID - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tile_x_q <= '0;
      tile_y_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

endmodule

// File: rtl/grid_region_loader.sv
// Scans the difference image tile by tile and presents each tile as one region word.
// First request 1 cycle after i_start; region held in HOLD until i_region_ready, reads stop meanwhile.
module grid_region_loader
  import paint_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int GRID  = DEF_GRID,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  grid_region_loader_if.master bus,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NPIX = GRID * GRID;
  localparam int NTX  = IMG_W / GRID;
  localparam int NTY  = IMG_H / GRID;
  localparam int TXW  = (NTX > 1) ? $clog2(NTX) : 1;
  localparam int TYW  = (NTY > 1) ? $clog2(NTY) : 1;
  localparam int RW   = $clog2(NPIX + 1);
  localparam int BW   = $clog2(NPIX * DW);

  state_e               state_q, state_d;
  logic [RW-1:0]        recv_q, recv_d;
  logic                 issued_q, issued_d;
  logic [NPIX*DW-1:0]   region_q, region_d;
  logic                 region_valid_q, region_valid_d;
  logic                 done_q, done_d;

  logic                 clear;
  logic                 tile_adv;
  logic                 req_acc;
  logic                 last_req;
  logic                 last_tile;
  logic [BW-1:0]        wr_base;

  assign bus.mem_rd = (state_q == ST_FETCH) && !issued_q;
  assign req_acc    = bus.mem_rd && !bus.mem_wait;
  assign wr_base    = BW'(32'(recv_q) * 32'(DW));

  grid_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .GRID  (GRID),
    .AW    (AW),
    .TXW   (TXW),
    .TYW   (TYW)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (clear),
    .i_req_acc   (req_acc),
    .i_tile_adv  (tile_adv),
    .o_addr      (bus.mem_addr),
    .o_last_req  (last_req),
    .o_last_tile (last_tile),
    .o_tile_x    (bus.tile_x),
    .o_tile_y    (bus.tile_y)
  );

  always_comb begin
    state_d  = state_q;
    recv_d   = recv_q;
    issued_d = issued_q;
    region_d = region_q;
    clear    = 1'b0;
    tile_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_FETCH;
          recv_d   = '0;
          issued_d = 1'b0;
          clear    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (req_acc && last_req) issued_d = 1'b1;
        // Returns are only captured here, so stale data after a reset is dropped.
        if (bus.mem_rvalid) begin
          region_d[wr_base +: DW] = bus.mem_rdata;
          recv_d = recv_q + 1'b1;
          if (recv_q == RW'(NPIX - 1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.region_ready) begin
          tile_adv = 1'b1;
          recv_d   = '0;
          issued_d = 1'b0;
          state_d  = last_tile ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    region_valid_d = (state_d == ST_HOLD);
    done_d         = (state_q == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      recv_q         <= '0;
      issued_q       <= 1'b0;
      region_q       <= '0;
      region_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      recv_q         <= recv_d;
      issued_q       <= issued_d;
      region_q       <= region_d;
      region_valid_q <= region_valid_d;
      done_q         <= done_d;
    end
  end

  assign bus.region       = region_q;
  assign bus.region_valid = region_valid_q;
  assign o_busy           = (state_q != ST_IDLE);
  assign o_done           = done_q;

endmodule
